audio_stream_ctrl: RTL and testbench

- Sequences one stereo sample at a time from the codec input FIFO, through an external effect pipeline, to the codec output FIFO.
- Owns the codec handshake: `audio_in_available`/`read_audio_in` on input, `audio_out_allowed`/`write_audio_out` on output.
- Owns a valid/ready dispatch-and-return handshake to the processing datapath.
- Sits between the codec interface and the effect chain in `top`; applies mute/bypass and recovers from a hung pipeline via a watchdog.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/audio_watchdog.sv | 29 ++
 rtl/audio_stream_ctrl.sv | 150 +++++++++++++++
 tb/tb_audio_stream_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio stream controller slice.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        WAIT_RES,
        LOAD,
        WAIT_OUT
    } ctrl_state_e;

    localparam stereo_t SILENCE = '0;

endpackage

// File: rtl/audio_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags expiry on the TIMEOUT_CYC-th one.
module audio_watchdog
    import audio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/audio_stream_ctrl.sv
// Moves one stereo sample at a time from the codec input, through the effect
// pipeline (or mute/bypass), to the codec output, with a dispatch watchdog.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              cfg_mute,
    input  logic              cfg_bypass,
    input  logic              audio_in_available,
    input  logic [DATA_W-1:0] audio_in_L,
    input  logic [DATA_W-1:0] audio_in_R,
    output logic              read_audio_in,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [DATA_W-1:0] audio_out_L,
    output logic [DATA_W-1:0] audio_out_R,
    output logic              proc_valid,
    input  logic              proc_ready,
    output logic [DATA_W-1:0] proc_L,
    output logic [DATA_W-1:0] proc_R,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_L,
    input  logic [DATA_W-1:0] res_R,
    output logic [CNT_W-1:0]  sample_count,
    output logic              timeout_err,
    output logic              busy
);

    ctrl_state_e       r_state;
    ctrl_state_e       w_next_state;
    stereo_t           r_smp;
    stereo_t           r_val;
    stereo_t           r_out;
    logic              r_rd;
    logic              r_wr;
    logic              r_mute;
    logic              r_bypass;
    logic              r_terr;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_wd_en;
    logic              w_expire;

    assign w_wd_en = (r_state == DISPATCH) || (r_state == WAIT_RES);

    audio_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk    (CLOCK_50),
        .i_rst_n  (reset_n),
        .i_clr    (!w_wd_en),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // IDLE stays put for the pop cycle; routing happens on the edge read_audio_in falls.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:     if (r_rd) w_next_state = (r_mute || r_bypass) ? LOAD : DISPATCH;
            DISPATCH: if (w_expire) w_next_state = LOAD;
                      else if (proc_ready) w_next_state = WAIT_RES;
            WAIT_RES: if (res_valid || w_expire) w_next_state = LOAD;
            LOAD:     w_next_state = WAIT_OUT;
            WAIT_OUT: if (audio_out_allowed) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_smp    <= SILENCE;
            r_val    <= SILENCE;
            r_out    <= SILENCE;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_mute   <= 1'b0;
            r_bypass <= 1'b0;
            r_terr   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_rd) begin
                        r_val <= r_mute ? SILENCE : r_smp;
                    end else if (audio_in_available) begin
                        r_rd     <= 1'b1;
                        r_smp.l  <= audio_in_L;
                        r_smp.r  <= audio_in_R;
                        r_mute   <= cfg_mute;
                        r_bypass <= cfg_bypass;
                    end
                end
                DISPATCH: begin
                    if (w_expire) begin
                        r_val  <= SILENCE;
                        r_terr <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        r_val.l <= res_L;
                        r_val.r <= res_R;
                    end else if (w_expire) begin
                        r_val  <= SILENCE;
                        r_terr <= 1'b1;
                    end
                end
                LOAD: begin
                    r_out <= r_val;
                end
                WAIT_OUT: begin
                    if (audio_out_allowed) begin
                        r_wr <= 1'b1;
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_audio_in   = r_rd;
    assign write_audio_out = r_wr;
    assign audio_out_L     = r_out.l;
    assign audio_out_R     = r_out.r;
    assign proc_valid      = (r_state == DISPATCH);
    assign proc_L          = r_smp.l;
    assign proc_R          = r_smp.r;
    assign sample_count    = r_cnt;
    assign timeout_err     = r_terr;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl: bypass, mute, processing, backpressure,
// watchdog, back-to-back samples and mid-flight reset.
module tb_audio_stream_ctrl;

    logic        CLOCK_50;
    logic        reset_n;
    logic        cfg_mute;
    logic        cfg_bypass;
    logic        audio_in_available;
    logic [31:0] audio_in_L;
    logic [31:0] audio_in_R;
    logic        read_audio_in;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] audio_out_L;
    logic [31:0] audio_out_R;
    logic        proc_valid;
    logic        proc_ready;
    logic [31:0] proc_L;
    logic [31:0] proc_R;
    logic        res_valid;
    logic [31:0] res_L;
    logic [31:0] res_R;
    logic [2:0]  sample_count;
    logic        timeout_err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    int cyc_n = 0;
    int rd_n, wr_n, pv_n, pv_bad;
    int rd_at, wr_at, pv_first, to_at;
    logic        hold_avail = 1'b0;
    logic [31:0] pv_L, pv_R;
    logic [31:0] wr_L, wr_R, pre_L, pre_R, last_L, last_R;

    audio_stream_ctrl #(
        .DATA_W      (32),
        .TIMEOUT_CYC (16),
        .CNT_W       (3)
    ) dut (
        .CLOCK_50           (CLOCK_50),
        .reset_n            (reset_n),
        .cfg_mute           (cfg_mute),
        .cfg_bypass         (cfg_bypass),
        .audio_in_available (audio_in_available),
        .audio_in_L         (audio_in_L),
        .audio_in_R         (audio_in_R),
        .read_audio_in      (read_audio_in),
        .audio_out_allowed  (audio_out_allowed),
        .write_audio_out    (write_audio_out),
        .audio_out_L        (audio_out_L),
        .audio_out_R        (audio_out_R),
        .proc_valid         (proc_valid),
        .proc_ready         (proc_ready),
        .proc_L             (proc_L),
        .proc_R             (proc_R),
        .res_valid          (res_valid),
        .res_L              (res_L),
        .res_R              (res_R),
        .sample_count       (sample_count),
        .timeout_err        (timeout_err),
        .busy               (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // One cycle: wait for the falling edge, record pulses; single-entry codec FIFO empties on pop.
    task automatic cyc();
        @(negedge CLOCK_50);
        cyc_n++;
        if (read_audio_in) begin
            rd_n++;
            rd_at = cyc_n;
            if (!hold_avail) audio_in_available = 1'b0;
        end
        if (proc_valid) begin
            pv_n++;
            if (pv_first == 0) pv_first = cyc_n;
            if (proc_L !== pv_L || proc_R !== pv_R) pv_bad++;
        end
        if (timeout_err && to_at == 0) to_at = cyc_n;
        if (write_audio_out) begin
            wr_n++;
            wr_at = cyc_n;
            wr_L  = audio_out_L;
            wr_R  = audio_out_R;
            pre_L = last_L;
            pre_R = last_R;
        end
        last_L = audio_out_L;
        last_R = audio_out_R;
    endtask

    task automatic mon_clear();
        rd_n = 0; wr_n = 0; pv_n = 0; pv_bad = 0;
        rd_at = 0; wr_at = 0; pv_first = 0; to_at = 0;
    endtask

    task automatic bump_cnt();
        if (exp_cnt != 7) exp_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cfg_mute = 1'b0; cfg_bypass = 1'b0;
        audio_in_available = 1'b0; audio_in_L = '0; audio_in_R = '0;
        audio_out_allowed = 1'b0; proc_ready = 1'b0;
        res_valid = 1'b0; res_L = '0; res_R = '0;
        mon_clear();
        repeat (3) cyc();
        n_vec++; if ({read_audio_in, write_audio_out, proc_valid, timeout_err, busy} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000", {read_audio_in, write_audio_out, proc_valid, timeout_err, busy}); end
        n_vec++; if ({audio_out_L, audio_out_R} !== 64'h0) begin
            n_err++; $display("FAIL reset_out: got %h %h expected 0 0", audio_out_L, audio_out_R); end
        n_vec++; if ({proc_L, proc_R} !== 64'h0) begin
            n_err++; $display("FAIL reset_proc: got %h %h expected 0 0", proc_L, proc_R); end
        n_vec++; if (sample_count !== 3'd0) begin
            n_err++; $display("FAIL reset_count: got %0d expected 0", sample_count); end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_bypass();
        mon_clear();
        cfg_bypass = 1'b1; cfg_mute = 1'b0; audio_out_allowed = 1'b1;
        audio_in_L = 32'd1000; audio_in_R = -32'sd1000; audio_in_available = 1'b1;
        for (int i = 0; i < 12 && wr_n == 0; i++) cyc();
        cyc();
        bump_cnt();
        n_vec++; if (rd_n !== 1) begin n_err++; $display("FAIL bypass_reads: got %0d expected 1", rd_n); end
        n_vec++; if (wr_n !== 1) begin n_err++; $display("FAIL bypass_writes: got %0d expected 1", wr_n); end
        n_vec++; if ((wr_at - rd_at) !== 3) begin n_err++; $display("FAIL bypass_latency: got %0d expected 3", wr_at - rd_at); end
        n_vec++; if ({wr_L, wr_R} !== {32'd1000, 32'hFFFF_FC18}) begin
            n_err++; $display("FAIL bypass_data: got %h %h expected 000003e8 fffffc18", wr_L, wr_R); end
        n_vec++; if (sample_count !== 3'(exp_cnt)) begin n_err++; $display("FAIL bypass_count: got %0d expected %0d", sample_count, exp_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bypass_idle: got %b expected 0", busy); end
    endtask

    task automatic test_mute();
        mon_clear();
        cfg_mute = 1'b1; cfg_bypass = 1'b1;
        audio_in_L = 32'd5000; audio_in_R = 32'd5000; audio_in_available = 1'b1;
        for (int i = 0; i < 12 && wr_n == 0; i++) cyc();
        cyc();
        bump_cnt();
        cfg_mute = 1'b0; cfg_bypass = 1'b0;
        n_vec++; if (pv_n !== 0) begin n_err++; $display("FAIL mute_proc_valid: got %0d expected 0", pv_n); end
        n_vec++; if (wr_n !== 1) begin n_err++; $display("FAIL mute_writes: got %0d expected 1", wr_n); end
        n_vec++; if ({wr_L, wr_R} !== 64'h0) begin n_err++; $display("FAIL mute_data: got %h %h expected 0 0", wr_L, wr_R); end
        n_vec++; if (sample_count !== 3'(exp_cnt)) begin n_err++; $display("FAIL mute_count: got %0d expected %0d", sample_count, exp_cnt); end
    endtask

    task automatic test_process();
        int   v = 0;
        int   w = 0;
        logic acc = 1'b0;
        mon_clear();
        cfg_mute = 1'b0; cfg_bypass = 1'b0;
        audio_in_L = 32'hDEAD_BEEF; audio_in_R = 32'h0BAD_F00D; audio_in_available = 1'b1;
        pv_L = 32'hDEAD_BEEF; pv_R = 32'h0BAD_F00D;
        for (int i = 0; i < 40 && wr_n == 0; i++) begin
            cyc();
            proc_ready = 1'b0; res_valid = 1'b0;
            if (acc) begin
                w++;
                if (w == 5) begin res_valid = 1'b1; res_L = 32'h1234_5678; res_R = 32'h8765_4321; end
            end
            if (proc_valid) begin
                v++;
                // stray result while still dispatching must be ignored
                if (v == 1) begin res_valid = 1'b1; res_L = 32'hBAD0_BAD0; res_R = 32'hBAD0_BAD0; end
                if (v == 2) begin proc_ready = 1'b1; acc = 1'b1; end
            end
        end
        cyc();
        bump_cnt();
        n_vec++; if (pv_n !== 2) begin n_err++; $display("FAIL proc_valid_cycles: got %0d expected 2", pv_n); end
        n_vec++; if (pv_bad !== 0) begin n_err++; $display("FAIL proc_data_stable: got %0d bad cycles expected 0", pv_bad); end
        n_vec++; if (wr_n !== 1) begin n_err++; $display("FAIL proc_writes: got %0d expected 1", wr_n); end
        n_vec++; if ({wr_L, wr_R} !== {32'h1234_5678, 32'h8765_4321}) begin
            n_err++; $display("FAIL proc_result: got %h %h expected 12345678 87654321", wr_L, wr_R); end
        n_vec++; if ({pre_L, pre_R} !== {32'h1234_5678, 32'h8765_4321}) begin
            n_err++; $display("FAIL proc_pre_write: got %h %h expected 12345678 87654321", pre_L, pre_R); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL proc_no_timeout: got %b expected 0", timeout_err); end
        n_vec++; if (sample_count !== 3'(exp_cnt)) begin n_err++; $display("FAIL proc_count: got %0d expected %0d", sample_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        mon_clear();
        cfg_bypass = 1'b1; audio_out_allowed = 1'b0;
        audio_in_L = 32'h7FFF_FFFF; audio_in_R = 32'h8000_0000; audio_in_available = 1'b1;
        repeat (25) cyc();
        n_vec++; if (wr_n !== 0) begin n_err++; $display("FAIL bp_no_write: got %0d expected 0", wr_n); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy: got %b expected 1", busy); end
        n_vec++; if ({audio_out_L, audio_out_R} !== {32'h7FFF_FFFF, 32'h8000_0000}) begin
            n_err++; $display("FAIL bp_held: got %h %h expected 7fffffff 80000000", audio_out_L, audio_out_R); end
        audio_out_allowed = 1'b1;
        for (int i = 0; i < 6 && wr_n == 0; i++) cyc();
        cyc();
        bump_cnt();
        n_vec++; if (wr_n !== 1) begin n_err++; $display("FAIL bp_writes: got %0d expected 1", wr_n); end
        n_vec++; if ({wr_L, wr_R} !== {32'h7FFF_FFFF, 32'h8000_0000}) begin
            n_err++; $display("FAIL bp_data: got %h %h expected 7fffffff 80000000", wr_L, wr_R); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int v = 0;
        mon_clear();
        cfg_bypass = 1'b0;
        audio_in_L = 32'h1111_1111; audio_in_R = 32'h2222_2222; audio_in_available = 1'b1;
        pv_L = 32'h1111_1111; pv_R = 32'h2222_2222;
        for (int i = 0; i < 60 && wr_n == 0; i++) begin
            cyc();
            proc_ready = 1'b0;
            if (proc_valid) begin
                v++;
                if (v == 3) proc_ready = 1'b1;
            end
        end
        cyc();
        bump_cnt();
        n_vec++; if ((to_at - pv_first) !== 16) begin n_err++; $display("FAIL to_cycles: got %0d expected 16", to_at - pv_first); end
        n_vec++; if (pv_n !== 3) begin n_err++; $display("FAIL to_proc_valid: got %0d expected 3", pv_n); end
        n_vec++; if ({wr_n, wr_L, wr_R} !== {32'd1, 64'h0}) begin
            n_err++; $display("FAIL to_silence: got %0d writes %h %h expected 1 writes 0 0", wr_n, wr_L, wr_R); end
        n_vec++; if (sample_count !== 3'(exp_cnt)) begin n_err++; $display("FAIL to_count: got %0d expected %0d", sample_count, exp_cnt); end
        mon_clear();
        cfg_bypass = 1'b1;
        audio_in_L = 32'h0000_0042; audio_in_R = 32'hFFFF_FFBE; audio_in_available = 1'b1;
        for (int i = 0; i < 12 && wr_n == 0; i++) cyc();
        cyc();
        bump_cnt();
        n_vec++; if ({wr_n, wr_L, wr_R} !== {32'd1, 32'h0000_0042, 32'hFFFF_FFBE}) begin
            n_err++; $display("FAIL to_next_sample: got %0d writes %h %h expected 1 writes 00000042 ffffffbe", wr_n, wr_L, wr_R); end
        n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    endtask

    task automatic test_back_to_back();
        int rdk = 0, wk = 0, rd2 = 0, w1_at = 0, w1_to_r2;
        logic [31:0] w1L = '0, w1R = '0, w2L = '0, w2R = '0;
        mon_clear();
        hold_avail = 1'b1; cfg_bypass = 1'b1; audio_out_allowed = 1'b1;
        audio_in_L = 32'h0000_0001; audio_in_R = 32'hFFFF_FFFF; audio_in_available = 1'b1;
        for (int i = 0; i < 30 && wk < 2; i++) begin
            cyc();
            if (read_audio_in) begin
                rdk++;
                if (rdk == 1) begin audio_in_L = 32'h8000_0000; audio_in_R = 32'h7FFF_FFFF; end
                else begin rd2 = cyc_n; audio_in_available = 1'b0; end
            end
            if (write_audio_out) begin
                wk++;
                if (wk == 1) begin w1L = audio_out_L; w1R = audio_out_R; w1_at = cyc_n; end
                else begin w2L = audio_out_L; w2R = audio_out_R; end
            end
        end
        cyc();
        hold_avail = 1'b0;
        bump_cnt(); bump_cnt();
        w1_to_r2 = rd2 - w1_at;
        n_vec++; if (rd_n !== 2) begin n_err++; $display("FAIL b2b_reads: got %0d expected 2", rd_n); end
        n_vec++; if (w1_to_r2 !== 1) begin n_err++; $display("FAIL b2b_reread: got %0d expected 1", w1_to_r2); end
        n_vec++; if ({w1L, w1R} !== {32'h0000_0001, 32'hFFFF_FFFF}) begin
            n_err++; $display("FAIL b2b_first: got %h %h expected 00000001 ffffffff", w1L, w1R); end
        n_vec++; if ({w2L, w2R} !== {32'h8000_0000, 32'h7FFF_FFFF}) begin
            n_err++; $display("FAIL b2b_second: got %h %h expected 80000000 7fffffff", w2L, w2R); end
        n_vec++; if (sample_count !== 3'(exp_cnt)) begin n_err++; $display("FAIL b2b_count_saturate: got %0d expected %0d", sample_count, exp_cnt); end
    endtask

    task automatic test_reset_midflight();
        int   w = 0;
        logic acc = 1'b0;
        mon_clear();
        cfg_bypass = 1'b0;
        audio_in_L = 32'h5555_5555; audio_in_R = 32'hAAAA_AAAA; audio_in_available = 1'b1;
        pv_L = 32'h5555_5555; pv_R = 32'hAAAA_AAAA;
        for (int i = 0; i < 20 && w < 3; i++) begin
            cyc();
            proc_ready = 1'b0;
            if (acc) w++;
            if (proc_valid) begin proc_ready = 1'b1; acc = 1'b1; end
        end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        exp_cnt = 0;
        n_vec++; if ({read_audio_in, write_audio_out, proc_valid, timeout_err, busy} !== 5'b0) begin
            n_err++; $display("FAIL rst_flags: got %b expected 00000", {read_audio_in, write_audio_out, proc_valid, timeout_err, busy}); end
        n_vec++; if ({audio_out_L, audio_out_R, proc_L, proc_R} !== 128'h0) begin
            n_err++; $display("FAIL rst_data: got %h %h %h %h expected all 0", audio_out_L, audio_out_R, proc_L, proc_R); end
        n_vec++; if (sample_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", sample_count); end
        mon_clear();
        res_valid = 1'b1; res_L = 32'h9999_9999; res_R = 32'h9999_9999;
        cyc();
        res_valid = 1'b0;
        repeat (6) cyc();
        n_vec++; if ({wr_n, rd_n} !== {32'd0, 32'd0}) begin
            n_err++; $display("FAIL rst_stray_res: got %0d writes %0d reads expected 0 0", wr_n, rd_n); end
        n_vec++; if ({busy, audio_out_L} !== 33'h0) begin
            n_err++; $display("FAIL rst_stray_state: got busy %b out %h expected 0 0", busy, audio_out_L); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_mute();
        test_process();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
